dl_lock_sched: RTL and testbench

// Time-multiplexes the single calibration-pulse slot between N_CH dynamic lockboxes (dl instances).

---
 rtl/dl_lock_sched.sv | 184 ++++++++++++++++++
 tb/tb_dl_lock_sched.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dl_lock_sched.sv
// Round-robin owner of the single calibration-pulse slot shared by N_CH lockboxes.
// Pulses are combinational off registered state; no backpressure, requests are fire-and-forget.
module dl_lock_sched #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int TMO_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [N_CH-1:0]   ch_en,
  input  logic [15:0]       cal_period,
  input  logic [TMO_W-1:0]  lock_timeout,
  input  logic [3:0]        max_retries,
  input  logic [N_CH-1:0]   lock_done_in,
  output logic [N_CH-1:0]   trig_lock_out,
  output logic [N_CH-1:0]   lock_sig_active_out,
  output logic              cal_pulse_req,
  output logic [CH_W-1:0]   active_ch,
  output logic [N_CH-1:0]   ch_locked,
  output logic [N_CH-1:0]   ch_fault,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_SERVE, S_RETRY} state_e;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   act_q, act_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [15:0]       per_q, per_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [3:0]        retry_q, retry_d;
  logic [1:0]        qual_q, qual_d;
  logic [N_CH-1:0]   locked_q, locked_d;
  logic [N_CH-1:0]   fault_q, fault_d;
  logic              en_q, en_d;

  logic [15:0]       per_load;
  logic [N_CH-1:0]   eligible;
  logic [N_CH-1:0]   act_oh;
  logic              act_en;
  logic              pulse;
  logic              tmo_hit;
  logic              sel_found;
  logic [CH_W-1:0]   sel_ch;

  assign per_load = (cal_period == 16'd0) ? 16'd1 : cal_period;
  assign eligible = ch_en & ~fault_q;
  assign act_oh   = N_CH'(1) << act_q;
  assign act_en   = ch_en[act_q];
  assign pulse    = (state_q == S_SERVE) && act_en && (per_q == 16'd1);
  assign tmo_hit  = (lock_timeout != '0) && (tmo_q == TMO_W'(1));

  // Lowest eligible index at or above rr_q wins; otherwise wrap to the lowest eligible overall.
  always_comb begin
    logic            lo_found, hi_found;
    logic [CH_W-1:0] lo_ch, hi_ch;
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_ch    = '0;
    hi_ch    = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lo_found = 1'b1;
        lo_ch    = CH_W'(i);
        if (CH_W'(i) >= rr_q) begin
          hi_found = 1'b1;
          hi_ch    = CH_W'(i);
        end
      end
    end
    sel_found = lo_found;
    sel_ch    = hi_found ? hi_ch : lo_ch;
  end

  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    rr_d     = rr_q;
    per_d    = per_q;
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    qual_d   = qual_q;
    locked_d = locked_q & ch_en;
    fault_d  = fault_q & ch_en;
    en_d     = enable;

    if (!enable) begin
      state_d  = S_IDLE;
      act_d    = '0;
      locked_d = '0;
      fault_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|eligible) state_d = S_SELECT;
        end
        S_SELECT: begin
          if (sel_found) begin
            act_d   = sel_ch;
            rr_d    = (sel_ch == CH_W'(N_CH - 1)) ? '0 : sel_ch + 1'b1;
            per_d   = per_load;
            tmo_d   = lock_timeout;
            retry_d = 4'd0;
            qual_d  = 2'd0;
            state_d = S_SERVE;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SERVE: begin
          if (!act_en) begin
            state_d = S_SELECT;
          end else begin
            per_d = (per_q == 16'd1) ? per_load : per_q - 1'b1;
            if (lock_timeout != '0) tmo_d = tmo_q - 1'b1;
            if (pulse) qual_d = lock_done_in[act_q] ? qual_q + 2'd1 : 2'd0;
            // A qualifying pulse on the timeout cycle takes precedence over the timeout.
            if (pulse && lock_done_in[act_q] && qual_q == 2'd1) begin
              locked_d = locked_d | act_oh;
              state_d  = S_SELECT;
            end else if (tmo_hit) begin
              locked_d = locked_d & ~act_oh;
              if (retry_q < max_retries) begin
                retry_d = retry_q + 4'd1;
                state_d = S_RETRY;
              end else begin
                fault_d = fault_d | act_oh;
                state_d = S_SELECT;
              end
            end
          end
        end
        S_RETRY: begin
          if (!act_en) begin
            state_d = S_SELECT;
          end else begin
            per_d   = per_load;
            tmo_d   = lock_timeout;
            qual_d  = 2'd0;
            state_d = S_SERVE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      act_q    <= '0;
      rr_q     <= '0;
      per_q    <= '0;
      tmo_q    <= '0;
      retry_q  <= '0;
      qual_q   <= '0;
      locked_q <= '0;
      fault_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      rr_q     <= rr_d;
      per_q    <= per_d;
      tmo_q    <= tmo_d;
      retry_q  <= retry_d;
      qual_q   <= qual_d;
      locked_q <= locked_d;
      fault_q  <= fault_d;
      en_q     <= en_d;
    end
  end

  // The served dl is held out of trig_lock for the single RETRY cycle to reset it.
  assign trig_lock_out       = en_q ? (ch_en & ~fault_q & ((state_q == S_RETRY) ? ~act_oh : '1)) : '0;
  assign cal_pulse_req       = pulse;
  assign lock_sig_active_out = pulse ? act_oh : '0;
  assign active_ch           = act_q;
  assign ch_locked           = locked_q;
  assign ch_fault            = fault_q;
  assign busy                = (state_q != S_IDLE);

endmodule

// File: tb/tb_dl_lock_sched.sv
// Bench for dl_lock_sched: directed scenarios plus random traffic against a window-based model.
module tb_dl_lock_sched;
  localparam int N = 4;
  localparam int PH_IDLE = 0, PH_SEL = 1, PH_SERVE = 2, PH_RETRY = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [N-1:0] ch_en;
  logic [15:0]  cal_period;
  logic [23:0]  lock_timeout;
  logic [3:0]   max_retries;
  logic [N-1:0] lock_done_in;
  logic [N-1:0] trig_lock_out;
  logic [N-1:0] lock_sig_active_out;
  logic         cal_pulse_req;
  logic [1:0]   active_ch;
  logic [N-1:0] ch_locked;
  logic [N-1:0] ch_fault;
  logic         busy;

  always #5 clk = ~clk;

  dl_lock_sched #(.N_CH(N), .CH_W(2), .TMO_W(24)) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_en(ch_en), .cal_period(cal_period),
    .lock_timeout(lock_timeout), .max_retries(max_retries), .lock_done_in(lock_done_in),
    .trig_lock_out(trig_lock_out), .lock_sig_active_out(lock_sig_active_out),
    .cal_pulse_req(cal_pulse_req), .active_ch(active_ch), .ch_locked(ch_locked),
    .ch_fault(ch_fault), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: a service window is tracked by how many SERVE cycles have elapsed.
  int           m_phase, m_ch, m_rr, m_el, m_tries, m_streak;
  logic [N-1:0] m_locked, m_fault;
  logic         m_en_q;

  int plog_ch[$];
  int plog_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int period();
    return (cal_period == 16'd0) ? 1 : int'(cal_period);
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_ch = 0; m_rr = 0; m_el = 0; m_tries = 0; m_streak = 0;
    m_locked = '0; m_fault = '0; m_en_q = 1'b0;
  endtask

  task automatic check_cycle();
    logic         pulse;
    logic [N-1:0] oh, e_trig;
    oh     = 4'b0001 << m_ch;
    pulse  = (m_phase == PH_SERVE) && ch_en[m_ch] && (((m_el + 1) % period()) == 0);
    e_trig = m_en_q ? (ch_en & ~m_fault & ((m_phase == PH_RETRY) ? ~oh : 4'b1111)) : 4'b0000;
    chk("cal_pulse_req", 32'(cal_pulse_req), 32'(pulse));
    chk("lock_sig_active", 32'(lock_sig_active_out), pulse ? 32'(oh) : 32'd0);
    chk("trig_lock", 32'(trig_lock_out), 32'(e_trig));
    chk("active_ch", 32'(active_ch), 32'(m_ch));
    chk("ch_locked", 32'(ch_locked), 32'(m_locked));
    chk("ch_fault", 32'(ch_fault), 32'(m_fault));
    chk("busy", 32'(busy), 32'(m_phase != PH_IDLE));
    if (cal_pulse_req) begin
      plog_ch.push_back(int'(active_ch));
      plog_t.push_back(cyc);
    end
  endtask

  task automatic model_update();
    logic [N-1:0] lk, ft;
    logic         found, qualified;
    int           c, idx;
    if (rst) begin
      model_reset();
      return;
    end
    lk = m_locked & ch_en;
    ft = m_fault & ch_en;
    if (!enable) begin
      m_phase = PH_IDLE; m_ch = 0; lk = '0; ft = '0;
    end else begin
      case (m_phase)
        PH_IDLE: if ((ch_en & ~m_fault) != 0) m_phase = PH_SEL;
        PH_SEL: begin
          found = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (!found && ch_en[c] && !m_fault[c]) begin
              found = 1'b1;
              m_ch  = c;
            end
          end
          if (found) begin
            m_rr = (m_ch + 1) % N; m_el = 0; m_tries = 0; m_streak = 0; m_phase = PH_SERVE;
          end else begin
            m_phase = PH_IDLE;
          end
        end
        PH_SERVE: begin
          if (!ch_en[m_ch]) begin
            m_phase = PH_SEL;
          end else begin
            idx = m_el + 1;
            qualified = 1'b0;
            if (idx % period() == 0) begin
              m_streak = lock_done_in[m_ch] ? m_streak + 1 : 0;
              if (m_streak == 2) begin
                lk[m_ch] = 1'b1; m_phase = PH_SEL; qualified = 1'b1;
              end
            end
            if (!qualified) begin
              if (lock_timeout != 0 && idx == int'(lock_timeout)) begin
                lk[m_ch] = 1'b0;
                if (m_tries < int'(max_retries)) begin
                  m_tries++; m_phase = PH_RETRY;
                end else begin
                  ft[m_ch] = 1'b1; m_phase = PH_SEL;
                end
              end else begin
                m_el = idx;
              end
            end
          end
        end
        default: begin
          if (!ch_en[m_ch]) m_phase = PH_SEL;
          else begin
            m_el = 0; m_streak = 0; m_phase = PH_SERVE;
          end
        end
      endcase
    end
    m_locked = lk;
    m_fault  = ft;
    m_en_q   = enable;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    model_update();
    cyc++;
    #1;
  endtask

  task automatic quiesce();
    enable = 1'b0;
    tick();
  endtask

  initial begin
    int retry_lows;
    int hit;
    rst = 1'b1; enable = 1'b0; ch_en = '0; cal_period = 16'd5; lock_timeout = '0;
    max_retries = '0; lock_done_in = '0;
    model_reset();
    @(posedge clk); #1;
    repeat (2) tick();

    // Round-robin over channels 0,1,3 with lock_done held high.
    rst = 1'b0; ch_en = 4'b1011; lock_done_in = 4'b1111; enable = 1'b1;
    plog_ch.delete(); plog_t.delete();
    repeat (40) tick();
    chk("rr_locked_all", 32'(ch_locked), 32'h0000000b);
    chk("rr_pulse_count", 32'(plog_ch.size() >= 6), 32'd1);
    if (plog_ch.size() >= 6) begin
      chk("rr_order0", 32'(plog_ch[0]), 32'd0);
      chk("rr_order1", 32'(plog_ch[1]), 32'd0);
      chk("rr_order2", 32'(plog_ch[2]), 32'd1);
      chk("rr_order3", 32'(plog_ch[3]), 32'd1);
      chk("rr_order4", 32'(plog_ch[4]), 32'd3);
      chk("rr_order5", 32'(plog_ch[5]), 32'd3);
      chk("rr_gap", 32'(plog_t[1] - plog_t[0]), 32'd5);
    end

    // Reset mid-SERVE while channel 1 is served (rr pointer then at 2).
    hit = 0;
    for (int i = 0; i < 60 && hit == 0; i++) begin
      tick();
      if (m_phase == PH_SERVE && m_ch == 1 && m_el == 2) hit = 1;
    end
    chk("rst_reach_serve_ch1", 32'(hit), 32'd1);
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig", 32'(trig_lock_out), 32'd0);
    chk("rst_locked", 32'(ch_locked), 32'd0);
    chk("rst_active", 32'(active_ch), 32'd0);
    chk("rst_req", 32'(cal_pulse_req), 32'd0);
    rst = 1'b0;
    plog_ch.delete(); plog_t.delete();
    repeat (12) tick();
    chk("rst_first_pulse_seen", 32'(plog_ch.size() > 0), 32'd1);
    if (plog_ch.size() > 0) chk("rst_rr_restart", 32'(plog_ch[0]), 32'd0);

    // Timeout/retry exhaustion on channel 0.
    quiesce();
    ch_en = 4'b0001; lock_timeout = 24'd20; max_retries = 4'd2; lock_done_in = '0; cal_period = 16'd5;
    tick();
    enable = 1'b1;
    retry_lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busy && !trig_lock_out[0] && !ch_fault[0]) retry_lows++;
    end
    chk("tmo_retry_lows", 32'(retry_lows), 32'd2);
    chk("tmo_fault", 32'(ch_fault), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);

    // Second pulse lands on the timeout cycle: qualification must win.
    quiesce();
    lock_timeout = 24'd10; max_retries = 4'd0; lock_done_in = 4'b0001;
    tick();
    enable = 1'b1;
    retry_lows = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy && !trig_lock_out[0]) retry_lows++;
    end
    chk("tie_locked", 32'(ch_locked), 32'd1);
    chk("tie_no_fault", 32'(ch_fault), 32'd0);
    chk("tie_no_retry", 32'(retry_lows), 32'd0);

    // Abort: drop ch_en[2] on its pulse-due cycle after it had locked once.
    quiesce();
    ch_en = 4'b0100; lock_timeout = '0; lock_done_in = 4'b0100;
    tick();
    enable = 1'b1;
    for (int i = 0; i < 40 && !m_locked[2]; i++) tick();
    chk("abort_prelocked", 32'(ch_locked[2]), 32'd1);
    lock_done_in = '0;
    hit = 0;
    for (int i = 0; i < 40 && hit == 0; i++) begin
      tick();
      if (m_phase == PH_SERVE && m_ch == 2 && m_el == 4) hit = 1;
    end
    chk("abort_reach_serve", 32'(hit), 32'd1);
    ch_en = 4'b0000;
    plog_ch.delete(); plog_t.delete();
    repeat (10) tick();
    chk("abort_no_pulse", 32'(plog_ch.size()), 32'd0);
    chk("abort_locked_clr", 32'(ch_locked), 32'd0);
    chk("abort_fault_clr", 32'(ch_fault), 32'd0);

    // cal_period of zero gives a pulse every SERVE cycle.
    quiesce();
    ch_en = 4'b0001; cal_period = 16'd0; lock_done_in = '0;
    tick();
    enable = 1'b1;
    plog_ch.delete(); plog_t.delete();
    repeat (10) tick();
    chk("p0_pulse_count", 32'(plog_ch.size()), 32'd8);

    // Random traffic with periodic reconfiguration while idle.
    for (int blk = 0; blk < 16; blk++) begin
      quiesce();
      cal_period   = 16'($urandom_range(0, 6));
      lock_timeout = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 25));
      max_retries  = 4'($urandom_range(0, 3));
      ch_en        = 4'($urandom_range(0, 15));
      tick();
      enable = 1'b1;
      for (int i = 0; i < 200; i++) begin
        for (int b = 0; b < N; b++) begin
          lock_done_in[b] = ($urandom_range(0, 9) < 7);
          if ($urandom_range(0, 39) == 0) ch_en[b] = ~ch_en[b];
        end
        enable = ($urandom_range(0, 299) != 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
